// File: rtl/rf_wport_arb.sv
// Write-port arbiter and scoreboard for a 2^AW x DW register file.
// Port 0 (writeback) has default priority. Port 1 (multi-cycle unit) is
// forced through after STARVE_MAX consecutive stalled cycles. A pending-bit
// scoreboard tracks outstanding port-1 destinations and drives decode hazards.
module rf_wport_arb #(
    parameter int STARVE_MAX = 4,
    parameter int DW         = 32,
    parameter int AW         = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          v0,
    output logic          rdy0,
    input  logic [AW-1:0] w0_reg,
    input  logic [DW-1:0] w0_data,
    input  logic          v1,
    output logic          rdy1,
    input  logic [AW-1:0] w1_reg,
    input  logic [DW-1:0] w1_data,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_reg,
    input  logic [AW-1:0] chk_ra,
    input  logic [AW-1:0] chk_rb,
    output logic          hz_a,
    output logic          hz_b,
    output logic          claim_err,
    output logic          rf_we,
    output logic [AW-1:0] rf_rw,
    output logic [DW-1:0] rf_rd
);

    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            force1;
    logic            xfer0;
    logic            xfer1;
    logic            claim_ok;
    logic            dup_claim;

    // Arbitration: port 0 wins by default, port 1 wins once it has starved.
    always_comb begin
        force1 = (starve_cnt == SW'(STARVE_MAX));
        rdy0   = !(force1 && v1);
        rdy1   = !v0 || force1;
        xfer0  = v0 && rdy0;
        xfer1  = v1 && rdy1;
    end

    // Scoreboard next state: a claim in the same cycle as the clearing write
    // for that register wins, since a new op is now outstanding.
    always_comb begin
        // NOTE: default every combinational output first so no latch is inferred.
        pend_nxt  = pend;
        claim_ok  = claim_en && (claim_reg != '0);
        dup_claim = claim_ok && pend[claim_reg] && !(xfer1 && (w1_reg == claim_reg));
        if (xfer1)    pend_nxt[w1_reg]    = 1'b0;
        if (claim_ok) pend_nxt[claim_reg] = 1'b1;
    end

    // Starvation counter: counts consecutive stalled cycles of port 1.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!clrn) begin
            starve_cnt <= '0;
        end else if (!v1 || xfer1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Output register toward the register file; r0 writes complete silently.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rf_we <= 1'b0;
            rf_rw <= '0;
            rf_rd <= '0;
        end else if (xfer0) begin
            rf_we <= (w0_reg != '0);
            rf_rw <= w0_reg;
            rf_rd <= w0_data;
        end else if (xfer1) begin
            rf_we <= (w1_reg != '0);
            rf_rw <= w1_reg;
            rf_rd <= w1_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Pending bits and the double-claim error pulse.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset.
        if (!clrn) begin
            pend      <= '0;
            claim_err <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            claim_err <= dup_claim;
        end
    end

    // Read hazards: outstanding result, or a write still in the output register.
    always_comb begin
        hz_a = (chk_ra != '0) && (pend[chk_ra] || (rf_we && (rf_rw == chk_ra)));
        hz_b = (chk_rb != '0) && (pend[chk_rb] || (rf_we && (rf_rw == chk_rb)));
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_rf_wport_arb;

    localparam int STARVE_MAX = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0, claim_en = 1'b0;
    logic [AW-1:0] w0_reg = '0, w1_reg = '0, claim_reg = '0, chk_ra = '0, chk_rb = '0;
    logic [DW-1:0] w0_data = '0, w1_data = '0;
    logic          rdy0, rdy1, hz_a, hz_b, claim_err, rf_we;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_rd;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit [31:0]     m_pend;
    int            m_stall;
    bit            m_we;
    bit [AW-1:0]   m_rw;
    bit [DW-1:0]   m_rd;
    bit            m_err;

    rf_wport_arb #(.STARVE_MAX(STARVE_MAX), .DW(DW), .AW(AW)) dut (
        .clk(clk), .clrn(clrn),
        .v0(v0), .rdy0(rdy0), .w0_reg(w0_reg), .w0_data(w0_data),
        .v1(v1), .rdy1(rdy1), .w1_reg(w1_reg), .w1_data(w1_data),
        .claim_en(claim_en), .claim_reg(claim_reg),
        .chk_ra(chk_ra), .chk_rb(chk_rb), .hz_a(hz_a), .hz_b(hz_b),
        .claim_err(claim_err), .rf_we(rf_we), .rf_rw(rf_rw), .rf_rd(rf_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_stall = 0; m_we = 0; m_rw = '0; m_rd = '0; m_err = 0;
    endtask

    function automatic bit model_hz(input bit [AW-1:0] r);
        if (r == 0) return 0;
        return m_pend[r] || (m_we && m_rw == r);
    endfunction

    // One clock cycle: entered just after a falling edge with inputs applied.
    task automatic cyc();
        bit starved, win0, win1, e_rdy0, e_rdy1;
        bit n_err;
        #1;
        starved = (m_stall >= STARVE_MAX);
        e_rdy0  = !(v1 && starved);
        e_rdy1  = !v0 || starved;
        win0    = v0 && e_rdy0;
        win1    = v1 && e_rdy1;
        check("rdy0", rdy0, e_rdy0);
        check("rdy1", rdy1, e_rdy1);
        check("hz_a", hz_a, model_hz(chk_ra));
        check("hz_b", hz_b, model_hz(chk_rb));
        check("claim_err", claim_err, m_err);
        check("rf_we", rf_we, m_we);
        check("rf_rw", rf_rw, m_rw);
        check("rf_rd", rf_rd, m_rd);
        n_err = claim_en && claim_reg != 0 && m_pend[claim_reg] && !(win1 && w1_reg == claim_reg);
        @(posedge clk);
        m_err = n_err;
        if (win0) begin
            m_we = (w0_reg != 0); m_rw = w0_reg; m_rd = w0_data;
        end else if (win1) begin
            m_we = (w1_reg != 0); m_rw = w1_reg; m_rd = w1_data;
        end else begin
            m_we = 0;
        end
        if (!v1 || win1) m_stall = 0;
        else if (m_stall < STARVE_MAX) m_stall++;
        if (win1) m_pend[w1_reg] = 0;
        if (claim_en && claim_reg != 0) m_pend[claim_reg] = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; claim_en = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;

        // Reset mid-burst: claim r5, stream port-0 writes, then pull reset.
        claim_en = 1; claim_reg = 5; cyc();
        claim_en = 0; chk_ra = 5; chk_rb = 5;
        for (int i = 0; i < 3; i++) begin
            v0 = 1; w0_reg = AW'(2); w0_data = 32'hA000 + i; cyc();
        end
        #3 clrn = 1'b0;
        #1;
        check("rst_we", rf_we, 0);
        check("rst_rw", rf_rw, 0);
        check("rst_rd", rf_rd, 0);
        check("rst_hz_a", hz_a, 0);
        check("rst_hz_b", hz_b, 0);
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        v0 = 1; w0_reg = 3; w0_data = 32'h1234; cyc();
        v0 = 0;
        #1;
        check("post_rst_we", rf_we, 1);
        check("post_rst_rw", rf_rw, 3);
        check("post_rst_rd", rf_rd, 32'h1234);
        cyc();

        // Priority and starvation: port 1 gets every fifth cycle.
        chk_ra = 0; chk_rb = 0;
        for (int i = 0; i < 10; i++) begin
            v0 = 1; w0_reg = AW'(10 + i); w0_data = 32'hB000 + i;
            v1 = 1; w1_reg = AW'(20); w1_data = 32'hC000 + i;
            #1;
            check("starve_rdy1", rdy1, (i % 5) == 4);
            check("starve_rdy0", rdy0, (i % 5) != 4);
            cyc();
        end
        idle(); cyc();

        // Write to r0 completes the handshake but never writes.
        v1 = 1; w1_reg = 0; w1_data = 32'hFFFF_FFFF;
        #1; check("r0_rdy1", rdy1, 1);
        cyc();
        v1 = 0;
        #1; check("r0_we", rf_we, 0);
        cyc();

        // Scoreboard: claim r7, then retire it through port 1.
        claim_en = 1; claim_reg = 7; cyc();
        claim_en = 0; chk_ra = 7;
        #1; check("sb_hz_set", hz_a, 1);
        cyc();
        v1 = 1; w1_reg = 7; w1_data = 32'h7777; cyc();
        v1 = 0;
        #1; check("sb_hz_inflight", hz_a, 1);
        cyc();
        #1; check("sb_hz_clear", hz_a, 0);
        cyc();

        // Simultaneous set/clear on r9, then an illegal double claim.
        claim_en = 1; claim_reg = 9; cyc();
        claim_en = 1; claim_reg = 9; v1 = 1; w1_reg = 9; w1_data = 32'h9999; cyc();
        idle(); chk_rb = 9;
        #1;
        check("sc_err", claim_err, 0);
        check("sc_hz_b", hz_b, 1);
        cyc();
        claim_en = 1; claim_reg = 9; cyc();
        claim_en = 0;
        #1; check("dup_err_pulse", claim_err, 1);
        cyc();
        #1; check("dup_err_done", claim_err, 0);
        cyc();

        // Back-to-back port-0 writes with no bubbles.
        for (int i = 1; i <= 8; i++) begin
            v0 = 1; w0_reg = AW'(i); w0_data = 32'hD000 + i;
            cyc();
            #1;
            check("b2b_we", rf_we, 1);
            check("b2b_rw", rf_rw, i);
        end
        idle(); cyc();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            v0 = ($urandom_range(0, 9) < 6);
            v1 = ($urandom_range(0, 9) < 5);
            w0_reg = AW'($urandom_range(0, 7));
            w1_reg = AW'($urandom_range(0, 7));
            w0_data = $urandom;
            w1_data = $urandom;
            claim_en = ($urandom_range(0, 3) == 0);
            claim_reg = AW'($urandom_range(0, 7));
            chk_ra = AW'($urandom_range(0, 7));
            chk_rb = AW'($urandom_range(0, 7));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
